logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: Logic_Unit_Arbiter

---
 rtl/logic_unit_arbiter_if.sv | 38 +++
 rtl/logic_unit_arbiter.sv | 119 +++++++++++
 tb/tb_logic_unit_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_arbiter_if.sv
// Requester, response and shared-unit signals of the logic unit arbiter.
// The arbiter side uses the slave modport; the requesters and unit model use master.
interface logic_unit_arbiter_if;
    logic       req_valid_0;
    logic       req_valid_1;
    logic [3:0] req_a_0;
    logic [3:0] req_b_0;
    logic [3:0] req_a_1;
    logic [3:0] req_b_1;
    logic [1:0] req_sel_0;
    logic [1:0] req_sel_1;
    logic       req_ready_0;
    logic       req_ready_1;
    logic [3:0] unit_a;
    logic [3:0] unit_b;
    logic [1:0] unit_sel;
    logic [3:0] unit_out;
    logic       resp_valid_0;
    logic       resp_valid_1;
    logic [3:0] resp_data;
    logic       resp_ready_0;
    logic       resp_ready_1;
    logic       busy;

    modport slave (
        input  req_valid_0, req_valid_1, req_a_0, req_b_0, req_a_1, req_b_1,
               req_sel_0, req_sel_1, unit_out, resp_ready_0, resp_ready_1,
        output req_ready_0, req_ready_1, unit_a, unit_b, unit_sel,
               resp_valid_0, resp_valid_1, resp_data, busy
    );

    modport master (
        output req_valid_0, req_valid_1, req_a_0, req_b_0, req_a_1, req_b_1,
               req_sel_0, req_sel_1, unit_out, resp_ready_0, resp_ready_1,
        input  req_ready_0, req_ready_1, unit_a, unit_b, unit_sel,
               resp_valid_0, resp_valid_1, resp_data, busy
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two-port arbiter sharing one combinational NAND/NOR/complement unit, one op in flight.
// Define LOGIC_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module logic_unit_arbiter (
    input  logic clk,
    input  logic rst_n,
    logic_unit_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] op_a_reg;
    logic [3:0] op_b_reg;
    logic [1:0] op_sel_reg;
    logic       op_id_reg;
    logic [3:0] resp_data_reg;

    logic       grant_valid;
    logic       grant_id;
    logic       accept;
    logic       resp_take;

`ifdef LOGIC_ARB_ROUND_ROBIN_EN
    // ptr_reg names the port that wins when both request: the one not granted last.
    logic ptr_reg;

    always_comb begin
        grant_valid = bus.req_valid_0 | bus.req_valid_1;
        if (bus.req_valid_0 && bus.req_valid_1) begin
            grant_id = ptr_reg;
        end else begin
            grant_id = ~bus.req_valid_0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg <= 1'b0;
        end else if (accept) begin
            ptr_reg <= ~grant_id;
        end
    end
`else
    always_comb begin
        grant_valid = bus.req_valid_0 | bus.req_valid_1;
        grant_id    = ~bus.req_valid_0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        resp_take  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                resp_take = op_id_reg ? bus.resp_ready_1 : bus.resp_ready_0;
                if (resp_take) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand registers feed the unit in every state, so its inputs move only on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a_reg      <= 4'd0;
            op_b_reg      <= 4'd0;
            op_sel_reg    <= 2'd0;
            op_id_reg     <= 1'b0;
            resp_data_reg <= 4'd0;
        end else begin
            if (accept) begin
                op_a_reg   <= grant_id ? bus.req_a_1   : bus.req_a_0;
                op_b_reg   <= grant_id ? bus.req_b_1   : bus.req_b_0;
                op_sel_reg <= grant_id ? bus.req_sel_1 : bus.req_sel_0;
                op_id_reg  <= grant_id;
            end
            if (state_reg == EXEC) begin
                resp_data_reg <= bus.unit_out;
            end
        end
    end

    // Handshake outputs are forced low while reset is asserted.
    assign bus.req_ready_0  = rst_n & accept & ~grant_id;
    assign bus.req_ready_1  = rst_n & accept &  grant_id;
    assign bus.resp_valid_0 = rst_n & (state_reg == RESP) & ~op_id_reg;
    assign bus.resp_valid_1 = rst_n & (state_reg == RESP) &  op_id_reg;
    assign bus.busy         = rst_n & (state_reg != IDLE);
    assign bus.resp_data    = resp_data_reg;
    assign bus.unit_a       = op_a_reg;
    assign bus.unit_b       = op_b_reg;
    assign bus.unit_sel     = op_sel_reg;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-level model.
module tb_logic_unit_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

`ifdef LOGIC_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic_unit_arbiter_if bus ();
    logic_unit_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Shared unit: 00 NAND, 01 NOR, 10 NOT A, 11 NOT B.
    function automatic logic [3:0] unit_fn(logic [3:0] a, logic [3:0] b, logic [1:0] sel);
        case (sel)
            2'd0:    return ~(a & b);
            2'd1:    return ~(a | b);
            2'd2:    return ~a;
            default: return ~b;
        endcase
    endfunction

    assign bus.unit_out = unit_fn(bus.unit_a, bus.unit_b, bus.unit_sel);

    typedef struct {
        logic       v0, v1;
        logic [3:0] a0, b0;
        logic [1:0] s0;
        logic [3:0] a1, b1;
        logic [1:0] s1;
        logic       rr0, rr1;
        logic       e_r0, e_r1, e_rv0, e_rv1, e_busy;
        logic       chk_d;
        logic [3:0] e_d;
    } vec_t;

    vec_t tbl [17];

    task automatic chk_b(string nm, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_n(string nm, logic [3:0] act, logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v0, logic v1, logic [3:0] a0, logic [3:0] b0, logic [1:0] s0,
                         logic [3:0] a1, logic [3:0] b1, logic [1:0] s1, logic rr0, logic rr1);
        bus.req_valid_0 = v0;  bus.req_valid_1 = v1;
        bus.req_a_0 = a0;      bus.req_b_0 = b0;     bus.req_sel_0 = s0;
        bus.req_a_1 = a1;      bus.req_b_1 = b1;     bus.req_sel_1 = s1;
        bus.resp_ready_0 = rr0; bus.resp_ready_1 = rr1;
    endtask

    task automatic idle_inputs();
        drive(0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Transaction-level reference: an op is either absent or in flight for some age.
    bit         m_inflight;
    int         m_age;
    bit         m_id;
    bit         m_last;
    logic [3:0] m_res, m_ua, m_ub;
    logic [1:0] m_us;

    task automatic model_reset();
        m_inflight = 0; m_age = 0; m_id = 0; m_last = 1'b1;
        m_res = 4'h0; m_ua = 4'h0; m_ub = 4'h0; m_us = 2'd0;
    endtask

    task automatic rand_cycle();
        logic g;
        logic e_r0, e_r1, e_rv0, e_rv1;
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom), 4'($urandom), 2'($urandom),
              4'($urandom), 4'($urandom), 2'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        #1;
        g = 1'b0;
        e_r0 = 0; e_r1 = 0; e_rv0 = 0; e_rv1 = 0;
        if (!m_inflight && (bus.req_valid_0 || bus.req_valid_1)) begin
            if (bus.req_valid_0 && bus.req_valid_1) g = RR ? ~m_last : 1'b0;
            else g = ~bus.req_valid_0;
            e_r0 = ~g; e_r1 = g;
        end
        if (m_inflight && m_age >= 1) begin
            e_rv0 = ~m_id; e_rv1 = m_id;
        end
        chk_b("rnd_ready0", bus.req_ready_0, e_r0);
        chk_b("rnd_ready1", bus.req_ready_1, e_r1);
        chk_b("rnd_rvalid0", bus.resp_valid_0, e_rv0);
        chk_b("rnd_rvalid1", bus.resp_valid_1, e_rv1);
        chk_b("rnd_busy", bus.busy, m_inflight);
        chk_n("rnd_unit_a", bus.unit_a, m_ua);
        chk_n("rnd_unit_b", bus.unit_b, m_ub);
        if (e_rv0 || e_rv1) chk_n("rnd_data", bus.resp_data, m_res);
        @(posedge clk);
        if (!m_inflight && (bus.req_valid_0 || bus.req_valid_1)) begin
            m_inflight = 1; m_age = 0; m_id = g; m_last = g;
            m_ua = g ? bus.req_a_1 : bus.req_a_0;
            m_ub = g ? bus.req_b_1 : bus.req_b_0;
            m_us = g ? bus.req_sel_1 : bus.req_sel_0;
            m_res = unit_fn(m_ua, m_ub, m_us);
            $display("txn port=%0d a=%h b=%h sel=%0d expect=%h", g, m_ua, m_ub, m_us, m_res);
        end else if (m_inflight) begin
            if (m_age >= 1 && (m_id ? bus.resp_ready_1 : bus.resp_ready_0)) m_inflight = 0;
            else m_age++;
        end
        #1;
    endtask

    initial begin
        int grants [4];
        int n;

        //           v0 v1 a0    b0    s0    a1    b1    s1   rr0 rr1 r0 r1 rv0 rv1 bsy chk d
        tbl[0]  = '{1, 0, 4'hA, 4'h6, 2'd0, 4'h0, 4'h0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0};
        tbl[1]  = '{0, 0, 4'hA, 4'h6, 2'd0, 4'h0, 4'h0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0};
        tbl[2]  = '{0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 1, 4'hD};
        tbl[3]  = '{0, 1, 4'h0, 4'h0, 2'd0, 4'h3, 4'h5, 2'd1, 0, 1, 0, 0, 1, 0, 1, 1, 4'hD};
        tbl[4]  = '{0, 1, 4'h0, 4'h0, 2'd0, 4'h3, 4'h5, 2'd1, 0, 1, 0, 0, 1, 0, 1, 1, 4'hD};
        tbl[5]  = '{0, 1, 4'h0, 4'h0, 2'd0, 4'h3, 4'h5, 2'd1, 1, 0, 0, 0, 1, 0, 1, 1, 4'hD};
        tbl[6]  = '{0, 1, 4'h0, 4'h0, 2'd0, 4'h3, 4'h5, 2'd1, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0};
        tbl[7]  = '{0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0};
        tbl[8]  = '{0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 0, 1, 0, 0, 0, 1, 1, 1, 4'h8};
        tbl[9]  = '{0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0};
        tbl[10] = '{1, 1, 4'hF, 4'h0, 2'd2, 4'h1, 4'h2, 2'd3, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0};
        tbl[11] = '{0, 1, 4'hF, 4'h0, 2'd2, 4'h1, 4'h2, 2'd3, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0};
        tbl[12] = '{0, 1, 4'hF, 4'h0, 2'd2, 4'h1, 4'h2, 2'd3, 1, 0, 0, 0, 1, 0, 1, 1, 4'h0};
        tbl[13] = '{0, 1, 4'hF, 4'h0, 2'd2, 4'h1, 4'h2, 2'd3, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0};
        tbl[14] = '{0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0};
        tbl[15] = '{0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 0, 1, 0, 0, 0, 1, 1, 1, 4'hD};
        tbl[16] = '{0, 0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0};

        // Reset with a request pending: handshake outputs stay low.
        drive(1, 1, 4'hF, 4'hF, 2'd0, 4'hF, 4'hF, 2'd0, 1, 1);
        step();
        chk_b("rst_ready0", bus.req_ready_0, 1'b0);
        chk_b("rst_ready1", bus.req_ready_1, 1'b0);
        chk_b("rst_busy", bus.busy, 1'b0);
        chk_b("rst_rvalid0", bus.resp_valid_0, 1'b0);
        chk_n("rst_unit_a", bus.unit_a, 4'h0);
        chk_n("rst_data", bus.resp_data, 4'h0);
        idle_inputs();
        do_reset();

        foreach (tbl[i]) begin
            drive(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].s0,
                  tbl[i].a1, tbl[i].b1, tbl[i].s1, tbl[i].rr0, tbl[i].rr1);
            #1;
            chk_b($sformatf("vec%0d_ready0", i), bus.req_ready_0, tbl[i].e_r0);
            chk_b($sformatf("vec%0d_ready1", i), bus.req_ready_1, tbl[i].e_r1);
            chk_b($sformatf("vec%0d_rvalid0", i), bus.resp_valid_0, tbl[i].e_rv0);
            chk_b($sformatf("vec%0d_rvalid1", i), bus.resp_valid_1, tbl[i].e_rv1);
            chk_b($sformatf("vec%0d_busy", i), bus.busy, tbl[i].e_busy);
            if (tbl[i].chk_d) chk_n($sformatf("vec%0d_data", i), bus.resp_data, tbl[i].e_d);
            step();
        end

        // Grant order with both ports requesting continuously.
        idle_inputs();
        do_reset();
        drive(1, 1, 4'h1, 4'h2, 2'd0, 4'h3, 4'h4, 2'd1, 1, 1);
        #1;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            if (bus.req_ready_0) begin grants[n] = 0; n++; end
            else if (bus.req_ready_1) begin grants[n] = 1; n++; end
            step();
        end
        chk_n("grant_count", 4'(n), 4'd4);
        for (int k = 0; k < n; k++) begin
            $display("grant %0d -> port %0d", k, grants[k]);
            chk_n($sformatf("grant%0d", k), 4'(grants[k]), RR ? 4'(k % 2) : 4'd0);
        end

        // Reset asserted during EXEC discards the operation.
        idle_inputs();
        do_reset();
        drive(1, 0, 4'h5, 4'h3, 2'd0, 4'h0, 4'h0, 2'd0, 1, 1);
        step();
        chk_b("exec_busy", bus.busy, 1'b1);
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_b("midrst_busy", bus.busy, 1'b0);
        chk_b("midrst_rvalid0", bus.resp_valid_0, 1'b0);
        chk_n("midrst_data", bus.resp_data, 4'h0);
        chk_n("midrst_unit_a", bus.unit_a, 4'h0);
        drive(0, 1, 4'h0, 4'h0, 2'd0, 4'h9, 4'h6, 2'd1, 1, 0);
        #1;
        chk_b("first_accept", bus.req_ready_1, 1'b1);
        step();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) chk_b("after_rst_rvalid1", bus.resp_valid_1, 1'b1);
            chk_b("no_stale_rvalid0", bus.resp_valid_0, 1'b0);
            step();
        end
        bus.resp_ready_1 = 1'b1;
        step();
        bus.resp_ready_1 = 1'b0;
        chk_b("after_rst_idle", bus.busy, 1'b0);

        // A one-cycle request on port 1 during EXEC is never accepted.
        drive(1, 0, 4'hC, 4'hA, 2'd1, 4'h0, 4'h0, 2'd0, 0, 0);
        step();
        drive(0, 1, 4'h0, 4'h0, 2'd0, 4'h7, 4'h7, 2'd0, 0, 0);
        #1;
        chk_b("pulse_ready1", bus.req_ready_1, 1'b0);
        step();
        idle_inputs();
        bus.resp_ready_0 = 1'b1;
        #1;
        chk_n("pulse_op0_data", bus.resp_data, 4'h1);
        step();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            chk_b("pulse_no_rvalid1", bus.resp_valid_1, 1'b0);
            chk_b("pulse_idle", bus.busy, 1'b0);
            step();
        end

        // Randomized traffic against the reference model.
        idle_inputs();
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
